// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline boundary registers.
//  - payload widths for each boundary (IF/ID, ID/EX, EX/MEM, MEM/WB)
//  - canonical NOP instruction (addi x0, x0, 0)
//  - packing helpers that build a bubble payload for each boundary
//  - occupancy type and a small helper that counts valid entries
package pipe_stage_buf_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int unsigned IF_ID_W  = 64;   // pc + instr
   localparam int unsigned ID_EX_W  = 128;  // pc + instr + rs1 value + rs2 value
   localparam int unsigned EX_MEM_W = 96;   // instr + alu result + store data
   localparam int unsigned MEM_WB_W = 64;   // instr + write-back data

   typedef logic [1:0] occ_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] alu_res;
      logic [31:0] st_data;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] wb_data;
   } mem_wb_t;

   function automatic logic [IF_ID_W-1:0] if_id_nop();
      if_id_t p;
      p.pc    = '0;
      p.instr = NOP_INSTR;
      return p;
   endfunction

   function automatic logic [ID_EX_W-1:0] id_ex_nop();
      id_ex_t p;
      p.pc      = '0;
      p.instr   = NOP_INSTR;
      p.rs1_val = '0;
      p.rs2_val = '0;
      return p;
   endfunction

   function automatic logic [EX_MEM_W-1:0] ex_mem_nop();
      ex_mem_t p;
      p.instr   = NOP_INSTR;
      p.alu_res = '0;
      p.st_data = '0;
      return p;
   endfunction

   function automatic logic [MEM_WB_W-1:0] mem_wb_nop();
      mem_wb_t p;
      p.instr   = NOP_INSTR;
      p.wb_data = '0;
      return p;
   endfunction

   function automatic occ_t count_valid(input logic a, input logic b);
      return occ_t'({1'b0, a}) + occ_t'({1'b0, b});
   endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of a pipeline stage: a valid bit plus payload.
//  clock, reset (async, active low)
//  load      : capture load_data and mark valid (wins over clear)
//  clear     : drop the entry and refill the payload with NOP_VAL
//  load_data : payload to capture
//  valid     : entry holds a beat
//  data      : stored payload (NOP_VAL whenever the entry is empty)
module pipe_skid_entry
   import pipe_stage_buf_pkg::*;
#(
   parameter int unsigned        DATA_W  = 128,
   parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (clear) begin
         valid_d = 1'b0;
         data_d  = NOP_VAL;   // empty slots always read as a bubble
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= NOP_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage register.
//  SKID=0: single register, up_ready is combinational from dn_ready.
//  SKID=1: main (head) + skid entry, up_ready registered from skid emptiness.
// Ports:
//  clock, reset (async, active low)
//  up_valid/up_ready/up_data : upstream handshake and payload
//  dn_valid/dn_ready/dn_data : downstream handshake and head payload
//  flush, stall, nop         : controls, priority flush > stall > nop
//  occupancy                 : number of valid entries
//  bp_cnt                    : saturating count of backpressured cycles
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int unsigned        DATA_W  = 128,
   parameter int unsigned        SKID    = 1,
   parameter logic [DATA_W-1:0]  NOP_VAL = '0,
   parameter int unsigned        CNT_W   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [DATA_W-1:0] up_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data,
   input  logic              flush,
   input  logic              stall,
   input  logic              nop,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bp_cnt
);

   logic              stall_eff, nop_eff;
   logic              in_xfer, out_xfer, store;
   logic              up_ready_base;
   logic              main_load, main_clear;
   logic [DATA_W-1:0] main_load_data;
   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic              skid_valid;
   logic [CNT_W-1:0]  bp_cnt_q, bp_cnt_d;

   // flush overrides stall; nop only applies when neither is active
   assign stall_eff = stall & ~flush;
   assign nop_eff   = nop & ~flush & ~stall;

   assign up_ready = up_ready_base & ~stall_eff;
   assign dn_valid = main_valid & ~stall_eff;
   assign dn_data  = dn_valid ? main_data : NOP_VAL;

   assign in_xfer  = up_valid & up_ready;
   assign out_xfer = dn_valid & dn_ready;
   // a consumed beat is only kept when neither flushed nor killed
   assign store    = in_xfer & ~flush & ~nop_eff;

   pipe_skid_entry #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
   ) u_main (
      .clock     (clock),
      .reset     (reset),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_load_data),
      .valid     (main_valid),
      .data      (main_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_load, skid_clear, skid_valid_nx;
         logic [DATA_W-1:0] skid_data;
         logic              up_rdy_q, up_rdy_d;

         pipe_skid_entry #(
            .DATA_W  (DATA_W),
            .NOP_VAL (NOP_VAL)
         ) u_skid (
            .clock     (clock),
            .reset     (reset),
            .load      (skid_load),
            .clear     (skid_clear),
            .load_data (up_data),
            .valid     (skid_valid),
            .data      (skid_data)
         );

         always_comb begin
            main_load      = 1'b0;
            main_clear     = 1'b0;
            skid_load      = 1'b0;
            skid_clear     = 1'b0;
            main_load_data = up_data;
            if (flush) begin
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end else if (out_xfer) begin
               if (skid_valid) begin
                  // up_ready is low while skid is full, so no beat arrives now
                  main_load      = 1'b1;
                  main_load_data = skid_data;
                  skid_clear     = 1'b1;
               end else if (store) begin
                  main_load = 1'b1;
               end else begin
                  main_clear = 1'b1;
               end
            end else if (store) begin
               if (!main_valid) begin
                  main_load = 1'b1;
               end else begin
                  skid_load = 1'b1;
               end
            end
            skid_valid_nx = skid_load | (skid_valid & ~skid_clear);
            up_rdy_d      = ~skid_valid_nx;
         end

         // resets low so up_ready rises only on the first edge after release
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               up_rdy_q <= 1'b0;
            end else begin
               up_rdy_q <= up_rdy_d;
            end
         end

         assign up_ready_base = up_rdy_q;
      end else begin : g_single
         logic alive_q, alive_d;

         assign alive_d = 1'b1;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               alive_q <= 1'b0;
            end else begin
               alive_q <= alive_d;
            end
         end

         always_comb begin
            main_load      = 1'b0;
            main_clear     = 1'b0;
            main_load_data = up_data;
            if (flush) begin
               main_clear = 1'b1;
            end else if (store) begin
               main_load = 1'b1;
            end else if (out_xfer) begin
               main_clear = 1'b1;
            end
         end

         assign skid_valid    = 1'b0;
         assign up_ready_base = alive_q & (~main_valid | dn_ready);
      end
   endgenerate

   assign occupancy = count_valid(main_valid, skid_valid);

   // dn_valid is already low under stall, so stalled cycles never count
   always_comb begin
      bp_cnt_d = bp_cnt_q;
      if (dn_valid && !dn_ready && (bp_cnt_q != {CNT_W{1'b1}})) begin
         bp_cnt_d = bp_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bp_cnt_q <= '0;
      end else begin
         bp_cnt_q <= bp_cnt_d;
      end
   end

   assign bp_cnt = bp_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance share the
// same directed stimulus. A queue-level model predicts every output each
// cycle; literal expectations pin the model at key points.
module tb_pipe_stage_buf;

   localparam int          DW   = 8;
   localparam int          CW   = 4;
   localparam logic [7:0]  NOPV = 8'hA5;
   localparam int          BPMAX = 15;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       up_valid = 1'b0, dn_ready = 1'b0, flush = 1'b0, stall = 1'b0, nop = 1'b0;
   logic [7:0] up_data = 8'h00;

   logic       s_up_ready, s_dn_valid, o_up_ready, o_dn_valid;
   logic [7:0] s_dn_data, o_dn_data;
   logic [1:0] s_occ, o_occ;
   logic [3:0] s_bp, o_bp;

   always #5 clock = ~clock;

   pipe_stage_buf #(.DATA_W(DW), .SKID(1), .NOP_VAL(NOPV), .CNT_W(CW)) dut_s (
      .clock(clock), .reset(reset),
      .up_valid(up_valid), .up_ready(s_up_ready), .up_data(up_data),
      .dn_valid(s_dn_valid), .dn_ready(dn_ready), .dn_data(s_dn_data),
      .flush(flush), .stall(stall), .nop(nop),
      .occupancy(s_occ), .bp_cnt(s_bp)
   );

   pipe_stage_buf #(.DATA_W(DW), .SKID(0), .NOP_VAL(NOPV), .CNT_W(CW)) dut_o (
      .clock(clock), .reset(reset),
      .up_valid(up_valid), .up_ready(o_up_ready), .up_data(up_data),
      .dn_valid(o_dn_valid), .dn_ready(dn_ready), .dn_data(o_dn_data),
      .flush(flush), .stall(stall), .nop(nop),
      .occupancy(o_occ), .bp_cnt(o_bp)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: k=0 is SKID=1, k=1 is SKID=0 ----
   logic [7:0] m_q [2][2];
   int         m_n [2];
   int         m_bp [2];
   bit         m_alive;
   bit         md_dv, md_ur, md_in, md_out;

   function automatic bit m_dv(input int k);
      return (m_n[k] > 0) && !(stall && !flush);
   endfunction

   function automatic bit m_ur(input int k);
      if (!m_alive || (stall && !flush)) return 1'b0;
      if (k == 0) return m_n[k] < 2;
      return (m_n[k] == 0) || dn_ready;
   endfunction

   function automatic logic [7:0] m_dd(input int k);
      return m_dv(k) ? m_q[k][0] : NOPV;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_alive = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_n[k]  = 0;
            m_bp[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            md_dv  = m_dv(k);
            md_ur  = m_ur(k);
            md_in  = up_valid && md_ur;
            md_out = md_dv && dn_ready;
            if (md_dv && !dn_ready && m_bp[k] < BPMAX) m_bp[k]++;
            if (flush) begin
               m_n[k] = 0;
            end else begin
               if (md_out) begin
                  m_q[k][0] = m_q[k][1];
                  m_n[k]--;
               end
               if (md_in && !nop) begin
                  m_q[k][m_n[k]] = up_data;
                  m_n[k]++;
               end
            end
         end
         m_alive = 1'b1;
      end
   end

   // ---------------- per-cycle compare + delivered-beat logs -------------
   logic [7:0] log_s [$];
   logic [7:0] log_o [$];

   always @(negedge clock) begin
      chk("s_up_ready", 32'(s_up_ready), 32'(m_ur(0)));
      chk("s_dn_valid", 32'(s_dn_valid), 32'(m_dv(0)));
      chk("s_dn_data",  32'(s_dn_data),  32'(m_dd(0)));
      chk("s_occ",      32'(s_occ),      32'(m_n[0]));
      chk("s_bp_cnt",   32'(s_bp),       32'(m_bp[0]));
      chk("o_up_ready", 32'(o_up_ready), 32'(m_ur(1)));
      chk("o_dn_valid", 32'(o_dn_valid), 32'(m_dv(1)));
      chk("o_dn_data",  32'(o_dn_data),  32'(m_dd(1)));
      chk("o_occ",      32'(o_occ),      32'(m_n[1]));
      chk("o_bp_cnt",   32'(o_bp),       32'(m_bp[1]));
      if (reset) begin
         if (s_dn_valid && dn_ready) log_s.push_back(s_dn_data);
         if (o_dn_valid && dn_ready) log_o.push_back(o_dn_data);
      end
   end

   // ---------------- stimulus ------------------------------------------
   task automatic drive(input logic uv, input logic [7:0] ud, input logic dr,
                        input logic fl, input logic st, input logic np);
      up_valid = uv;
      up_data  = ud;
      dn_ready = dr;
      flush    = fl;
      stall    = st;
      nop      = np;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [7:0] exp_s [11];
   logic [7:0] exp_o [10];

   initial begin
      exp_s = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'hA1, 8'hB2, 8'h66, 8'h99, 8'h61, 8'h62};
      exp_o = '{8'h11, 8'h22, 8'h33, 8'h11, 8'hA1, 8'hB2, 8'h66, 8'h99, 8'h61, 8'h62};

      // reset state
      tick();
      chk("rst s_up_ready", 32'(s_up_ready), 32'd0);
      chk("rst s_dn_valid", 32'(s_dn_valid), 32'd0);
      chk("rst s_dn_data",  32'(s_dn_data),  32'(NOPV));
      chk("rst s_occ",      32'(s_occ),      32'd0);
      chk("rst s_bp",       32'(s_bp),       32'd0);
      chk("rst o_up_ready", 32'(o_up_ready), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("release s_up_ready", 32'(s_up_ready), 32'd1);
      chk("release o_up_ready", 32'(o_up_ready), 32'd1);

      // 1: streaming with dn_ready high
      drive(1, 8'h11, 1, 0, 0, 0); tick();
      chk("t1 dn_data A", 32'(s_dn_data), 32'h11);
      drive(1, 8'h22, 1, 0, 0, 0); tick();
      chk("t1 dn_data B", 32'(s_dn_data), 32'h22);
      drive(1, 8'h33, 1, 0, 0, 0); tick();
      chk("t1 dn_data C", 32'(s_dn_data), 32'h33);
      chk("t1 occ",       32'(s_occ),     32'd1);
      drive(0, 8'h00, 1, 0, 0, 0); tick();
      chk("t1 drained",   32'(s_dn_valid), 32'd0);
      chk("t1 bp",        32'(s_bp),       32'd0);

      // 2: backpressure fills the skid slot
      drive(1, 8'h11, 0, 0, 0, 0); tick();
      chk("t2 occ A", 32'(s_occ), 32'd1);
      drive(1, 8'h22, 0, 0, 0, 0); tick();
      chk("t2 up_ready after B", 32'(s_up_ready), 32'd0);
      chk("t2 occ AB",           32'(s_occ),      32'd2);
      chk("t2 o_occ",            32'(o_occ),      32'd1);
      drive(0, 8'h00, 0, 0, 0, 0);
      repeat (4) tick();
      chk("t2 bp",   32'(s_bp), 32'd5);
      chk("t2 o_bp", 32'(o_bp), 32'd5);
      drive(0, 8'h00, 1, 0, 0, 0); tick();
      chk("t2 dn_data B",     32'(s_dn_data),  32'h22);
      chk("t2 up_ready back", 32'(s_up_ready), 32'd1);
      chk("t2 occ B",         32'(s_occ),      32'd1);
      tick();
      chk("t2 occ empty", 32'(s_occ), 32'd0);

      // 3: flush while full
      drive(1, 8'h77, 0, 0, 0, 0); tick();
      drive(1, 8'h88, 0, 0, 0, 0); tick();
      chk("t3 occ full", 32'(s_occ), 32'd2);
      drive(1, 8'h44, 0, 1, 0, 0); tick();
      chk("t3 occ",      32'(s_occ),      32'd0);
      chk("t3 dn_valid", 32'(s_dn_valid), 32'd0);
      chk("t3 dn_data",  32'(s_dn_data),  32'(NOPV));
      chk("t3 bp",       32'(s_bp),       32'd7);
      drive(0, 8'h00, 1, 0, 0, 0); tick();
      chk("t3 o_occ",    32'(o_occ),      32'd0);

      // 4: stall holds contents
      drive(1, 8'hA1, 0, 0, 0, 0); tick();
      drive(1, 8'hB2, 1, 0, 1, 0); #1;
      chk("t4 up_ready comb", 32'(s_up_ready), 32'd0);
      chk("t4 dn_valid comb", 32'(s_dn_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4 stall occ", 32'(s_occ), 32'd1);
         chk("t4 stall bp",  32'(s_bp),  32'd7);
         chk("t4 stall o_up_ready", 32'(o_up_ready), 32'd0);
      end
      drive(1, 8'hB2, 1, 0, 0, 0); tick();
      chk("t4 dn_data pending", 32'(s_dn_data), 32'hB2);
      chk("t4 occ",             32'(s_occ),     32'd1);
      drive(0, 8'h00, 1, 0, 0, 0); tick();

      // 5: bubble insert
      drive(1, 8'h55, 1, 0, 0, 1); tick();
      chk("t5 occ after nop",  32'(s_occ),      32'd0);
      chk("t5 dn_valid",       32'(s_dn_valid), 32'd0);
      drive(1, 8'h66, 1, 0, 0, 0); tick();
      chk("t5 dn_data F",      32'(s_dn_data),  32'h66);
      chk("t5 occ F",          32'(s_occ),      32'd1);
      drive(0, 8'h00, 1, 0, 0, 0); tick();

      // bp_cnt saturation
      drive(1, 8'h99, 0, 0, 0, 0); tick();
      drive(0, 8'h00, 0, 0, 0, 0);
      repeat (20) tick();
      chk("sat s_bp", 32'(s_bp), 32'd15);
      chk("sat o_bp", 32'(o_bp), 32'd15);
      drive(0, 8'h00, 1, 0, 0, 0); tick();
      chk("sat held", 32'(s_bp), 32'd15);

      // 6: SKID=0 ready tracking, then reset mid-stream
      drive(1, 8'h61, 1, 0, 0, 0); tick();
      drive(1, 8'h62, 0, 0, 0, 0); #1;
      chk("t6 o_up_ready low",  32'(o_up_ready), 32'd0);
      tick();
      drive(1, 8'h62, 1, 0, 0, 0); #1;
      chk("t6 o_up_ready high", 32'(o_up_ready), 32'd1);
      tick();
      drive(1, 8'h63, 1, 0, 0, 0); tick();
      chk("t6 o_dn_data", 32'(o_dn_data), 32'h63);
      chk("t6 o_occ",     32'(o_occ),     32'd1);
      reset = 1'b0; #1;
      chk("t6 rst o_dn_valid", 32'(o_dn_valid), 32'd0);
      chk("t6 rst o_up_ready", 32'(o_up_ready), 32'd0);
      chk("t6 rst o_bp",       32'(o_bp),       32'd0);
      chk("t6 rst s_dn_valid", 32'(s_dn_valid), 32'd0);
      chk("t6 rst s_occ",      32'(s_occ),      32'd0);
      chk("t6 rst s_dn_data",  32'(s_dn_data),  32'(NOPV));
      drive(0, 8'h00, 0, 0, 0, 0);
      tick();
      reset = 1'b1;
      tick();
      tick();

      // delivered sequences: no beat lost, duplicated, or leaked (44/55/77/88)
      chk("log_s count", 32'(log_s.size()), 32'd11);
      chk("log_o count", 32'(log_o.size()), 32'd10);
      for (int i = 0; i < 11; i++) begin
         if (i < log_s.size()) chk($sformatf("log_s[%0d]", i), 32'(log_s[i]), 32'(exp_s[i]));
      end
      for (int i = 0; i < 10; i++) begin
         if (i < log_o.size()) chk($sformatf("log_o[%0d]", i), 32'(log_o[i]), 32'(exp_o[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
